rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter for the 32-entry register file. It shares the file's single synchronous write port (`we`/`wa`/`wd`) among several execution units (ALU, load unit, mul/div) using a valid/ready handshake. Arbitration is round-robin by default. Each granted write is registered for one cycle before it reaches the register file, and is exposed on a pending-write port so decode can forward it.

## Interface
- `NUM_REQ`, 3, number of write-back requesters (2..8)
- `ADDR_WIDTH`, 5, register address width
- `DATA_WIDTH`, 32, register data width

- `clk` input 1 system clock, rising edge
- `rstn` input 1 reset, asynchronous, active-low
- `req_valid` input NUM_REQ per-requester write request
- `req_ready` output NUM_REQ per-requester grant; combinational from `req_valid`, `wb_hold`, `rr_ptr`
- `req_addr` input NUM_REQ*ADDR_WIDTH packed destination addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_data` input NUM_REQ*DATA_WIDTH packed write data, same packing
- `wb_hold` input 1 suppresses all grants this cycle
- `rf_we` output 1 to register file `we`
- `rf_wa` output ADDR_WIDTH to register file `wa`
- `rf_wd` output DATA_WIDTH to register file `wd`
- `pend_valid` output 1 high when a write is in flight and its address is non-zero
- `pend_addr` output ADDR_WIDTH in-flight address, equal to `rf_wa`
- `pend_data` output DATA_WIDTH in-flight data, equal to `rf_wd`

## Operation
- **Handshake**
  - A transfer occurs on requester i when `req_valid[i] && req_ready[i]`.
  - At most one `req_ready` bit is high per cycle.
  - `req_ready` is all-zero when `wb_hold` = 1 or when no `req_valid` bit is set.
  - A requester holds valid, addr and data stable until its grant. Dropping valid early is legal; the request is then not written.
- **Arbitration (round-robin)**
  - State register `rr_ptr`, range 0..NUM_REQ-1, resets to 0.
  - The winner is the first valid requester scanning upward from `rr_ptr` with wrap-around.
  - After a grant to i, `rr_ptr` becomes (i+1) mod NUM_REQ.
  - With no grant, including under `wb_hold`, `rr_ptr` holds.
- **Output stage**
  - On a grant, `rf_wa`/`rf_wd` capture the winner's addr/data and `rf_we` is set to 1.
  - With no grant, `rf_we` is set to 0 and `rf_wa`/`rf_wd` hold their previous values.
- **Address 0**
  - A grant with addr 0 completes the handshake normally but sets `rf_we` to 0.
  - r0 is never written and `pend_valid` stays low.
- **Pending port**
  - `pend_valid` = `rf_we`.
  - Decode compares each read address against `pend_addr` and substitutes `pend_data` on a match. This covers the cycle in which the register file still returns the old value.
- **Reset** (asynchronous, any time)
  - `rf_we`=0, `rf_wa`=0, `rf_wd`=0, `rr_ptr`=0, `pend_valid`=0.
  - A registered write that has not yet reached a clock edge is discarded.
  - `req_ready` is all-zero while `rstn` is low.

## Timing
- Request granted at edge k: `rf_we` is high during cycle k→k+1, and the register file is updated at edge k+1.
- Grant-to-architectural-write latency is 1 cycle. Throughput is one write per cycle.
- Back-to-back grants to the same address are legal. The later write wins, and `pend_*` always reflects the newer write.
- `wb_hold` acts in the same cycle. Deasserting it lets a grant happen in that same cycle.
- If only one requester is valid, it is granted every cycle regardless of `rr_ptr`.

## Configuration
- `RF_WB_FIXED_PRIO_EN`
  - **Defined:** fixed priority, requester 0 highest and NUM_REQ-1 lowest. `rr_ptr` is not implemented and lower-priority requesters may starve.
  - **Undefined (default):** round-robin as described under Operation.

## Structure
- **Package `rf_wb_pkg`**
  - Constants `RF_ADDR_WIDTH`=5, `RF_DATA_WIDTH`=32, `WB_NUM_REQ`=3.
  - Typedef `rf_addr_t`.
  - Typedef `wb_req_t` (valid, addr, data).
  - Requester index constants `WB_ALU`=0, `WB_LSU`=1, `WB_MDU`=2.
- **Sub-module `rr_arbiter`**
  - Parameter `N`.
  - Inputs: `req[N]`, `ptr`, `en`.
  - Outputs: one-hot `gnt[N]` and encoded `gnt_idx`.
  - Purely combinational. Owns the fixed-priority variant under the macro.
- **Top level:** holds `rr_ptr`, the output registers and the r0 filter.

## Test plan
- **Reset:** assert `rstn`=0 mid-stream with `rf_we`=1 → all outputs 0 immediately; after release, first grant goes to requester 0.
- **Round-robin fairness:** all three requesters valid continuously for 6 cycles → grants 0,1,2,0,1,2; `rf_wa` follows each requester's address one cycle later.
- **r0 filter:** requester 1 writes addr 0, data 0xDEADBEEF → `req_ready[1]`=1 and `rf_we`=0 next cycle; a read of r0 afterward returns 0.
- **Hold:** `wb_hold`=1 for 3 cycles with requesters 0 and 2 valid → `req_ready`=0 and `rr_ptr` unchanged; on release requester 0 is granted, then 2.
- **Pending/forward:** requester 0 writes r5=0x12345678 → next cycle `pend_valid`=1, `pend_addr`=5, `pend_data`=0x12345678; register file read of r5 shows the new value one cycle after that.
- **Fixed priority (macro defined):** requesters 0 and 2 valid for 4 cycles → requester 0 granted every cycle, requester 2 never granted.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package rf_wb_pkg;

   localparam int unsigned RF_ADDR_WIDTH = 5;
   localparam int unsigned RF_DATA_WIDTH = 32;
   localparam int unsigned WB_NUM_REQ    = 3;

   typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

   typedef struct packed {
      logic                     valid;
      rf_addr_t                 addr;
      logic [RF_DATA_WIDTH-1:0] data;
   } wb_req_t;

   localparam int unsigned WB_ALU = 0;
   localparam int unsigned WB_LSU = 1;
   localparam int unsigned WB_MDU = 2;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus: requester handshakes, register-file write port and pending-write port.
interface rf_wb_arbiter_if
   import rf_wb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = WB_NUM_REQ,
   parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic                          wb_hold;
   logic                          rf_we;
   logic [ADDR_WIDTH-1:0]         rf_wa;
   logic [DATA_WIDTH-1:0]         rf_wd;
   logic                          pend_valid;
   logic [ADDR_WIDTH-1:0]         pend_addr;
   logic [DATA_WIDTH-1:0]         pend_data;

   modport master (
      output req_valid, req_addr, req_data, wb_hold,
      input  req_ready, rf_we, rf_wa, rf_wd, pend_valid, pend_addr, pend_data
   );

   modport slave (
      input  req_valid, req_addr, req_data, wb_hold,
      output req_ready, rf_we, rf_wa, rf_wd, pend_valid, pend_addr, pend_data
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational one-of-N arbiter: round-robin from ptr, or fixed priority (0 highest)
// when RF_WB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   input  logic                 en,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx
);

   localparam int unsigned IW = $clog2(N);

`ifdef RF_WB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      logic          found;
      logic [IW-1:0] sel;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      sel     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         sel = IW'(k);
         if (en && !found && req[sel]) begin
            gnt[sel] = 1'b1;
            gnt_idx  = sel;
            found    = 1'b1;
         end
      end
   end
`else
   always_comb begin
      logic          found;
      logic [IW-1:0] sel;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      sel     = '0;
      // Scan upward from ptr with wrap-around; first valid requester wins.
      for (int unsigned k = 0; k < N; k++) begin
         sel = IW'((32'(ptr) + k) % N);
         if (en && !found && req[sel]) begin
            gnt[sel] = 1'b1;
            gnt_idx  = sel;
            found    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: grants one requester per cycle onto a registered register-file write port.
// Optional macro RF_WB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = WB_NUM_REQ,
   parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH
) (
   input logic            clk,
   input logic            rstn,
   rf_wb_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    gnt;
   logic [IDX_W-1:0]      gnt_idx;
   logic [IDX_W-1:0]      rr_ptr;
   logic                  arb_en;
   logic                  grant_any;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] wa_q;
   logic [DATA_WIDTH-1:0] wd_q;

   // Including rstn keeps req_ready low throughout reset.
   assign arb_en    = rstn & ~bus.wb_hold;
   assign grant_any = |gnt;

   rr_arbiter #(
      .N(NUM_REQ)
   ) u_arb (
      .req    (bus.req_valid),
      .ptr    (rr_ptr),
      .en     (arb_en),
      .gnt    (gnt),
      .gnt_idx(gnt_idx)
   );

`ifdef RF_WB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr <= '0;
      end else if (grant_any) begin
         rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end
`endif

   always_comb begin
      win_addr = '0;
      win_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_any && (IDX_W'(i) == gnt_idx)) begin
            win_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // A grant to r0 completes the handshake but never raises the write enable.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         we_q <= 1'b0;
         wa_q <= '0;
         wd_q <= '0;
      end else begin
         we_q <= grant_any && (win_addr != '0);
         if (grant_any) begin
            wa_q <= win_addr;
            wd_q <= win_data;
         end
      end
   end

   assign bus.req_ready  = gnt;
   assign bus.rf_we      = we_q;
   assign bus.rf_wa      = wa_q;
   assign bus.rf_wd      = wd_q;
   assign bus.pend_valid = we_q;
   assign bus.pend_addr  = wa_q;
   assign bus.pend_data  = wd_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a behavioural register file on the write port.
module tb_rf_wb_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic clk;
   logic rstn;
   int   tests;
   int   failed;

   logic [DW-1:0] mem [32];

   rf_wb_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   rf_wb_arbiter #(
      .NUM_REQ   (N),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: writes whatever the arbiter presents, so r0 stays 0 only if the DUT filters it.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
      end else if (bus.rf_we) begin
         mem[bus.rf_wa] <= bus.rf_wd;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn          = 1'b0;
      bus.wb_hold   = 1'b0;
      bus.req_valid = 3'b111;
      bus.req_addr  = {5'd3, 5'd2, 5'd1};
      bus.req_data  = {32'h3, 32'h2, 32'h1};
      #2;
      tests++;
      if (bus.req_ready !== 3'b000) begin
         failed++;
         $display("FAIL reset_ready: got %b want 000", bus.req_ready);
      end
      tests++;
      if (bus.rf_we !== 1'b0 || bus.rf_wa !== 5'd0 || bus.rf_wd !== 32'd0 || bus.pend_valid !== 1'b0)
      begin
         failed++;
         $display("FAIL reset_outputs: we=%b wa=%0d wd=%h pv=%b want all 0",
                  bus.rf_we, bus.rf_wa, bus.rf_wd, bus.pend_valid);
      end
      #1 rstn = 1'b1;
      bus.req_valid = 3'b001;
      bus.req_addr  = {5'd0, 5'd0, 5'd3};
      bus.req_data  = {32'h0, 32'h0, 32'h33};
      tick();
      bus.req_valid = 3'b000;
      tests++;
      if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd3) begin
         failed++;
         $display("FAIL pre_reset_write: we=%b wa=%0d want we=1 wa=3", bus.rf_we, bus.rf_wa);
      end
      // Asynchronous reset in mid-cycle while a write is in flight.
      #2 rstn = 1'b0;
      #1;
      tests++;
      if (bus.rf_we !== 1'b0 || bus.rf_wa !== 5'd0 || bus.rf_wd !== 32'd0 || bus.pend_valid !== 1'b0)
      begin
         failed++;
         $display("FAIL midreset_outputs: we=%b wa=%0d wd=%h pv=%b want all 0",
                  bus.rf_we, bus.rf_wa, bus.rf_wd, bus.pend_valid);
      end
      #2 rstn = 1'b1;
      bus.req_valid = 3'b111;
      #1;
      tests++;
      if (bus.req_ready !== 3'b001) begin
         failed++;
         $display("FAIL post_reset_first_grant: got %b want 001", bus.req_ready);
      end
      bus.req_valid = 3'b000;
      tick();
   endtask

   task automatic test_round_robin();
      int exp;
      bus.req_valid = 3'b111;
      bus.req_addr  = {5'd12, 5'd11, 5'd10};
      bus.req_data  = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
      #1;
      for (int c = 0; c < 6; c++) begin
         exp = c % 3;
         tests++;
         if (bus.req_ready !== 3'(1 << exp)) begin
            failed++;
            $display("FAIL rr_grant[%0d]: got %b want %b", c, bus.req_ready, 3'(1 << exp));
         end
         tick();
         tests++;
         if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'(10 + exp) || bus.rf_wd !== 32'hA000_0000 + exp)
         begin
            failed++;
            $display("FAIL rr_write[%0d]: we=%b wa=%0d wd=%h want we=1 wa=%0d", c, bus.rf_we,
                     bus.rf_wa, bus.rf_wd, 10 + exp);
         end
      end
      bus.req_valid = 3'b000;
      tick();
   endtask

   task automatic test_r0_filter();
      bus.req_valid = 3'b010;
      bus.req_addr  = {5'd0, 5'd0, 5'd0};
      bus.req_data  = {32'h0, 32'hDEAD_BEEF, 32'h0};
      #1;
      tests++;
      if (bus.req_ready !== 3'b010) begin
         failed++;
         $display("FAIL r0_ready: got %b want 010", bus.req_ready);
      end
      tick();
      bus.req_valid = 3'b000;
      tests++;
      if (bus.rf_we !== 1'b0 || bus.pend_valid !== 1'b0) begin
         failed++;
         $display("FAIL r0_we: we=%b pv=%b want 0 0", bus.rf_we, bus.pend_valid);
      end
      tick();
      tests++;
      if (mem[0] !== 32'd0) begin
         failed++;
         $display("FAIL r0_read: got %h want 0", mem[0]);
      end
   endtask

   task automatic test_hold();
      // Grant requester 2 first so the pointer sits at 0 before the hold.
      bus.req_valid = 3'b100;
      bus.req_addr  = {5'd9, 5'd0, 5'd7};
      bus.req_data  = {32'h99, 32'h0, 32'h77};
      tick();
      bus.req_valid = 3'b101;
      bus.wb_hold   = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests++;
         if (bus.req_ready !== 3'b000) begin
            failed++;
            $display("FAIL hold_ready[%0d]: got %b want 000", c, bus.req_ready);
         end
         tick();
         tests++;
         if (bus.rf_we !== 1'b0) begin
            failed++;
            $display("FAIL hold_we[%0d]: got %b want 0", c, bus.rf_we);
         end
      end
      bus.wb_hold = 1'b0;
      #1;
      tests++;
      if (bus.req_ready !== 3'b001) begin
         failed++;
         $display("FAIL hold_release_first: got %b want 001", bus.req_ready);
      end
      tick();
      bus.req_valid = 3'b100;
      #1;
      tests++;
      if (bus.rf_wa !== 5'd7 || bus.req_ready !== 3'b100) begin
         failed++;
         $display("FAIL hold_release_second: wa=%0d ready=%b want wa=7 ready=100",
                  bus.rf_wa, bus.req_ready);
      end
      tick();
      bus.req_valid = 3'b000;
      tests++;
      if (bus.rf_wa !== 5'd9 || bus.rf_wd !== 32'h99) begin
         failed++;
         $display("FAIL hold_release_write: wa=%0d wd=%h want wa=9 wd=99", bus.rf_wa, bus.rf_wd);
      end
   endtask

   task automatic test_pending();
      bus.req_valid = 3'b001;
      bus.req_addr  = {5'd0, 5'd0, 5'd5};
      bus.req_data  = {32'h0, 32'h0, 32'h1234_5678};
      tick();
      bus.req_valid = 3'b000;
      tests++;
      if (bus.pend_valid !== 1'b1 || bus.pend_addr !== 5'd5 || bus.pend_data !== 32'h1234_5678) begin
         failed++;
         $display("FAIL pend_port: pv=%b pa=%0d pd=%h want 1 5 12345678", bus.pend_valid,
                  bus.pend_addr, bus.pend_data);
      end
      tests++;
      if (mem[5] !== 32'd0) begin
         failed++;
         $display("FAIL pend_rf_old: got %h want 0", mem[5]);
      end
      tick();
      tests++;
      if (mem[5] !== 32'h1234_5678 || bus.pend_valid !== 1'b0) begin
         failed++;
         $display("FAIL pend_rf_new: r5=%h pv=%b want 12345678 0", mem[5], bus.pend_valid);
      end
   endtask

   task automatic test_back_to_back();
      bus.req_valid = 3'b001;
      bus.req_addr  = {5'd0, 5'd0, 5'd8};
      bus.req_data  = {32'h0, 32'h0, 32'hA};
      tick();
      bus.req_data = {32'h0, 32'h0, 32'hB};
      tests++;
      if (bus.pend_data !== 32'hA || bus.pend_valid !== 1'b1) begin
         failed++;
         $display("FAIL b2b_first: pd=%h pv=%b want a 1", bus.pend_data, bus.pend_valid);
      end
      tick();
      bus.req_valid = 3'b000;
      tests++;
      if (bus.pend_data !== 32'hB || bus.pend_addr !== 5'd8 || mem[8] !== 32'hA) begin
         failed++;
         $display("FAIL b2b_second: pd=%h pa=%0d r8=%h want b 8 a", bus.pend_data, bus.pend_addr,
                  mem[8]);
      end
      tick();
      tests++;
      if (mem[8] !== 32'hB) begin
         failed++;
         $display("FAIL b2b_final: r8=%h want b", mem[8]);
      end
   endtask

   task automatic test_fixed_prio();
      bus.req_valid = 3'b101;
      bus.req_addr  = {5'd14, 5'd0, 5'd13};
      bus.req_data  = {32'h2, 32'h0, 32'h1};
      #1;
      for (int c = 0; c < 4; c++) begin
         tests++;
         if (bus.req_ready !== 3'b001) begin
            failed++;
            $display("FAIL fixed_grant[%0d]: got %b want 001", c, bus.req_ready);
         end
         tick();
         tests++;
         if (bus.rf_wa !== 5'd13) begin
            failed++;
            $display("FAIL fixed_write[%0d]: wa=%0d want 13", c, bus.rf_wa);
         end
      end
      bus.req_valid = 3'b000;
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      test_reset();
`ifdef RF_WB_FIXED_PRIO_EN
      test_fixed_prio();
`else
      test_round_robin();
`endif
      test_r0_filter();
      test_hold();
      test_pending();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
